// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: ready/valid holding register plus sticky overrun/frame/parity flags.
// Build macro UART_RX_MAJORITY_EN enables 2-of-3 majority voting on every bit decision.
module uart_rx_param #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter bit          PARITY_EN   = 1'b0,
    parameter bit          PARITY_ODD  = 1'b0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 baud_tick,
    output logic                 baud_rst,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_data_valid,
    input  logic                 rx_data_ready,
    output logic                 overrun_err,
    output logic                 frame_err,
    output logic                 parity_err,
    input  logic                 err_clr
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] SampleLast = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SampleMid  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] DataLast   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] StopLast   = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_bad_q, par_bad_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d, frm_q, frm_d, par_q, par_d;
    logic                   rx_s, bit_val, at_bit, deliver, frame_set, load;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    assign rx_s   = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // Voting on noisy samples would be defeated by an early abort, so only the mid tick decides.
    localparam bit EarlyAbort = 1'b0;
    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (state_q == StIdle) begin
            vote_d = 2'b11;
        end else if (baud_tick) begin
            vote_d = {vote_q[0], rx_s};
        end
    end

    assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end
`else
    localparam bit EarlyAbort = 1'b1;
    assign bit_val = rx_s;
`endif

    assign at_bit   = baud_tick && (sample_cnt_q == SampleLast);
    assign baud_rst = (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        bit_cnt_d = bit_cnt_q;
        deliver   = 1'b0;
        frame_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                par_bad_d = 1'b0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (baud_tick && (sample_cnt_q == SampleMid)) begin
                    state_d = bit_val ? StIdle : StData;
                end else if (EarlyAbort && rx_s) begin
                    state_d = StIdle;
                end
            end
            StData: begin
                if (at_bit) begin
                    shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == DataLast) state_d = PARITY_EN ? StParity : StStop;
                end
            end
            StParity: begin
                if (at_bit) begin
                    par_bad_d = bit_val != ((^shift_q) ^ PARITY_ODD);
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (at_bit) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (!bit_val) begin
                        frame_set = 1'b1;
                        state_d   = StBreak;
                    end else if (bit_cnt_q == StopLast) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StBreak: begin
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) bit_cnt_d = '0;

        sample_cnt_d = sample_cnt_q;
        if ((state_d != state_q) || (state_q == StIdle)) begin
            sample_cnt_d = '0;
        end else if (baud_tick) begin
            sample_cnt_d = (sample_cnt_q == SampleLast) ? '0 : sample_cnt_q + 1'b1;
        end
    end

    // A word may load when the register is empty or is being drained in the same cycle.
    assign load = deliver && (!valid_q || rx_data_ready);

    always_comb begin
        data_d  = load ? shift_q : data_q;
        valid_d = valid_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && rx_data_ready) begin
            valid_d = 1'b0;
        end
        ovr_d = (deliver && !load)       ? 1'b1 : (err_clr ? 1'b0 : ovr_q);
        frm_d = frame_set                ? 1'b1 : (err_clr ? 1'b0 : frm_q);
        par_d = (deliver && par_bad_q)   ? 1'b1 : (err_clr ? 1'b0 : par_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sync_q       <= '1;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            ovr_q        <= 1'b0;
            frm_q        <= 1'b0;
            par_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            ovr_q        <= ovr_d;
            frm_q        <= frm_d;
            par_q        <= par_d;
        end
    end

    assign rx_data_o     = data_q;
    assign rx_data_valid = valid_q;
    assign overrun_err   = ovr_q;
    assign frame_err     = frm_q;
    assign parity_err    = par_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (default 8N1, even parity, 5 data + 2 stop bits)
// driven by directed frames and checked against a word-queue / flag model.
module tb_uart_rx_param;

    localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clk

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] rx_drv = 3'b111;
    logic [2:0] ready = 3'b000;
    logic [1:0] tcnt [3];
    wire  [2:0] tick, brst, valid, ovr, frm, par;
    wire  [7:0] d0, d1;
    wire  [4:0] d2;
    logic [8:0] dcur;

    int         cur = 0;
    int         n_checks = 0;
    int         n_err = 0;
    int         vcycles = 0;
    logic [8:0] last_seen = '0;
    logic [8:0] exp_q [$];
    bit         exp_ovr = 1'b0, exp_frm = 1'b0, exp_par = 1'b0;

    always #5 clk = ~clk;

    // Baud tick generators, each held in reset by its receiver's baud_rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            tcnt[i] <= (!rst_n || brst[i]) ? 2'd0 : tcnt[i] + 2'd1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_tick
        assign tick[g] = (tcnt[g] == 2'd3) && !brst[g];
    end

    uart_rx_param u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_drv[0]), .baud_tick(tick[0]), .baud_rst(brst[0]),
        .rx_data_o(d0), .rx_data_valid(valid[0]), .rx_data_ready(ready[0]),
        .overrun_err(ovr[0]), .frame_err(frm[0]), .parity_err(par[0]), .err_clr(err_clr)
    );

    uart_rx_param #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_drv[1]), .baud_tick(tick[1]), .baud_rst(brst[1]),
        .rx_data_o(d1), .rx_data_valid(valid[1]), .rx_data_ready(ready[1]),
        .overrun_err(ovr[1]), .frame_err(frm[1]), .parity_err(par[1]), .err_clr(err_clr)
    );

    uart_rx_param #(.DATA_BITS(5), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_drv[2]), .baud_tick(tick[2]), .baud_rst(brst[2]),
        .rx_data_o(d2), .rx_data_valid(valid[2]), .rx_data_ready(ready[2]),
        .overrun_err(ovr[2]), .frame_err(frm[2]), .parity_err(par[2]), .err_clr(err_clr)
    );

    always_comb begin
        case (cur)
            1:       dcur = {1'b0, d1};
            2:       dcur = {4'b0, d2};
            default: dcur = {1'b0, d0};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_overrun"}, 32'(ovr[cur]), 32'(exp_ovr));
        check({tag, "_frame"},   32'(frm[cur]), 32'(exp_frm));
        check({tag, "_parity"},  32'(par[cur]), 32'(exp_par));
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        clks(1);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_frm = 1'b0;
        exp_par = 1'b0;
        clks(2);
    endtask

    task automatic pulse_ready();
        ready[cur] = 1'b1;
        clks(1);
        ready[cur] = 1'b0;
        clks(2);
    endtask

    // Model: a frame with good stop bits is either queued or, if a word is held and the
    // consumer is stalled, dropped with overrun. Parity expected even (instance 1).
    task automatic send_frame(input logic [8:0] data, input int nbits, input bit par_en,
                              input bit par_bit, input int nstop, input logic [1:0] stops);
        logic [8:0] word;
        bit         good;
        bit         bad_par;
        word    = data & ((9'd1 << nbits) - 9'd1);
        good    = (nstop == 1) ? stops[0] : (stops[0] && stops[1]);
        bad_par = par_en && (par_bit != (^word));
        rx_drv[cur] = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            rx_drv[cur] = word[i];
            clks(BIT_CLKS);
        end
        if (par_en) begin
            rx_drv[cur] = par_bit;
            clks(BIT_CLKS);
        end
        for (int s = 0; s < nstop; s++) begin
            if ((s == nstop - 1) && good) begin
                if ((exp_q.size() > 0) && !ready[cur]) exp_ovr = 1'b1;
                else exp_q.push_back(word);
                if (bad_par) exp_par = 1'b1;
            end
            rx_drv[cur] = stops[s];
            clks(BIT_CLKS);
            if (!stops[s]) begin
                exp_frm = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_frm = 1'b0;
        exp_par = 1'b0;
        clks(2);
        rst_n = 1'b1;
        clks(1);
    endtask

    // Every cycle with valid high: the held word must be the model's oldest outstanding word.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n && valid[cur]) begin
                vcycles++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(valid[cur]), 32'd0);
                end else begin
                    check("rx_data_o", 32'(dcur), 32'(exp_q[0]));
                    last_seen = dcur;
                    if (ready[cur]) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        clks(3);
        rst_n = 1'b1;
        clks(2);
        check("reset_valid", 32'(valid[0]), 32'd0);
        check("reset_data", 32'(dcur), 32'd0);
        check("reset_baud_rst", 32'(brst[0]), 32'd1);
        check_flags("reset");

        // Basic 8N1 receive
        ready[0] = 1'b1;
        vcycles  = 0;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
        clks(4);
        check("basic_word", 32'(last_seen), 32'h0A5);
        check("basic_pulse_len", 32'(vcycles), 32'd1);
        check("basic_drained", 32'(exp_q.size()), 32'd0);
        check_flags("basic");

        // Back-pressure and overrun
        ready[0] = 1'b0;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 2'b11);
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1, 2'b11);
        check("bp_valid", 32'(valid[0]), 32'd1);
        check("bp_data", 32'(dcur), 32'h03C);
        check_flags("bp");
        pulse_ready();
        check("bp_valid_after_ready", 32'(valid[0]), 32'd0);
        pulse_err_clr();
        check_flags("bp_clr");

        // Framing error then held break
        ready[0] = 1'b1;
        send_frame(9'h0F0, 8, 1'b0, 1'b0, 1, 2'b00);
        clks(40 * BIT_CLKS);
        check("break_baud_rst", 32'(brst[0]), 32'd0);
        check("break_valid", 32'(valid[0]), 32'd0);
        check_flags("break");
        rx_drv[0] = 1'b1;
        clks(10);
        check("break_exit_idle", 32'(brst[0]), 32'd1);
        clks(BIT_CLKS);
        send_frame(9'h055, 8, 1'b0, 1'b0, 1, 2'b11);
        clks(4);
        check("after_break_word", 32'(last_seen), 32'h055);
        pulse_err_clr();

        // Glitch reject: 3-tick low pulse
        rx_drv[0] = 1'b0;
        clks(8);
        check("glitch_in_start", 32'(brst[0]), 32'd0);
        clks(4);
        rx_drv[0] = 1'b1;
        clks(BIT_CLKS);
        check("glitch_back_idle", 32'(brst[0]), 32'd1);
        check("glitch_valid", 32'(valid[0]), 32'd0);

        // Reset in the middle of the 4th data bit, with a word already held
        ready[0] = 1'b0;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 2'b11);
        check("pre_reset_valid", 32'(valid[0]), 32'd1);
        rx_drv[0] = 1'b0;
        clks(BIT_CLKS);
        rx_drv[0] = 1'b1;
        clks(3 * BIT_CLKS + BIT_CLKS / 2);
        check("pre_reset_busy", 32'(brst[0]), 32'd0);
        do_reset();
        check("post_reset_valid", 32'(valid[0]), 32'd0);
        check("post_reset_data", 32'(dcur), 32'd0);
        check("post_reset_idle", 32'(brst[0]), 32'd1);
        check_flags("post_reset");
        clks(BIT_CLKS);
        ready[0] = 1'b1;
        send_frame(9'h081, 8, 1'b0, 1'b0, 1, 2'b11);
        clks(4);
        check("post_reset_word", 32'(last_seen), 32'h081);

        // Even parity instance
        cur = 1;
        ready[1] = 1'b0;
        send_frame(9'h007, 8, 1'b1, 1'b0, 1, 2'b11);
        check("par_bad_valid", 32'(valid[1]), 32'd1);
        check("par_bad_data", 32'(dcur), 32'h007);
        check_flags("par_bad");
        pulse_ready();
        pulse_err_clr();
        ready[1] = 1'b1;
        send_frame(9'h007, 8, 1'b1, 1'b1, 1, 2'b11);
        clks(4);
        check("par_good_word", 32'(last_seen), 32'h007);
        check_flags("par_good");

        // 5 data bits, 2 stop bits
        cur = 2;
        ready[2] = 1'b1;
        send_frame(9'h013, 5, 1'b0, 1'b0, 2, 2'b11);
        clks(4);
        check("w5_word", 32'(last_seen), 32'h013);
        check_flags("w5_good");
        send_frame(9'h00A, 5, 1'b0, 1'b0, 2, 2'b01);
        check("w5_stop2_valid", 32'(valid[2]), 32'd0);
        check_flags("w5_stop2");
        rx_drv[2] = 1'b1;
        clks(10);
        check("w5_idle", 32'(brst[2]), 32'd1);
        check("w5_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
